// File: rtl/seven_segment_pkg.sv
// Shared seven-segment definitions: active-low glyph table, blank pattern, digit count.
package seven_segment_pkg;

  localparam int unsigned DIGITS  = 4;
  localparam int unsigned SEG_W   = 7;
  localparam int unsigned NIB_W   = 4;
  localparam int unsigned GLYPH_N = 16;

  localparam logic [SEG_W-1:0] BLANK = 7'b1111111;

  // Active-low {g,f,e,d,c,b,a}; index equals the hex value displayed.
  localparam logic [GLYPH_N-1:0][SEG_W-1:0] GLYPHS = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

  typedef struct packed {
    logic [DIGITS-1:0] en;
    logic              ca;
    logic [SEG_W-1:0]  pat;
  } seg_sample_t;

endpackage

// File: rtl/seven_segment_pattern_decoder.sv
// Combinational lookup of an active-low segment pattern into a hex nibble.
module seven_segment_pattern_decoder
  import seven_segment_pkg::*;
(
  input  logic [SEG_W-1:0] pattern_i,
  output logic [NIB_W-1:0] nibble_o,
  output logic             legal_o,
  output logic             blank_o
);

  always_comb begin
    nibble_o = '0;
    legal_o  = 1'b0;
    blank_o  = (pattern_i == BLANK);
    for (int unsigned i = 0; i < GLYPH_N; i++) begin
      if (pattern_i == GLYPHS[i]) begin
        nibble_o = NIB_W'(i);
        legal_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seven_segment_scan_decoder.sv
// Recovers four hex digits from a scanned seven-segment display by sampling
// each strobed digit until it has been stable for STABLE_CYCLES samples.
module seven_segment_scan_decoder
  import seven_segment_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SEG_W-1:0]        seven_segment_number,
  input  logic                    common_anod,
  input  logic [DIGITS-1:0]       digit_enable,
  output logic [DIGITS*NIB_W-1:0] four_bit_number,
  output logic [DIGITS-1:0]       digit_valid,
  output logic                    frame_valid,
  output logic                    pattern_error
);

  localparam int unsigned CNT_W      = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(STABLE_CYCLES - 1);

  seg_sample_t               smp_q, prev_q;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [DIGITS-1:0]         mask_q, mask_d;
  logic [DIGITS*NIB_W-1:0]   num_q, num_d;
  logic [DIGITS-1:0]         dv_q, dv_d;
  logic                      frame_q, frame_d;
  logic                      err_q, err_d;

  logic [SEG_W-1:0]          norm_c;
  logic [NIB_W-1:0]          nibble_c;
  logic                      legal_c, blank_c, capture_c, onehot_c;

  assign norm_c   = smp_q.ca ? smp_q.pat : ~smp_q.pat;
  assign onehot_c = $onehot(smp_q.en);

  seven_segment_pattern_decoder u_dec (
    .pattern_i (norm_c),
    .nibble_o  (nibble_c),
    .legal_o   (legal_c),
    .blank_o   (blank_c)
  );

  // Stability counting, capture, frame tracking.
  always_comb begin
    cnt_d     = cnt_q;
    mask_d    = mask_q;
    num_d     = num_q;
    dv_d      = dv_q;
    frame_d   = 1'b0;
    err_d     = 1'b0;
    capture_c = 1'b0;

    if (!onehot_c) begin
      cnt_d = '0;
    end else if (smp_q != prev_q) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q != CNT_MAX) begin
      cnt_d     = cnt_q + CNT_W'(1);
      capture_c = (cnt_q == CNT_PRE);
    end

    // Frame completes the cycle after the mask fills; a same-cycle capture re-seeds it.
    if (mask_q == '1) begin
      frame_d = 1'b1;
      mask_d  = '0;
    end

    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (capture_c && smp_q.en[i]) begin
        mask_d[i] = 1'b1;
        if (legal_c) begin
          num_d[i*NIB_W +: NIB_W] = nibble_c;
          dv_d[i]                 = 1'b1;
        end else begin
          dv_d[i] = 1'b0;
          err_d   = !blank_c;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      smp_q   <= '0;
      prev_q  <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
      num_q   <= '0;
      dv_q    <= '0;
      frame_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      smp_q   <= seg_sample_t'({digit_enable, common_anod, seven_segment_number});
      prev_q  <= smp_q;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      num_q   <= num_d;
      dv_q    <= dv_d;
      frame_q <= frame_d;
      err_q   <= err_d;
    end
  end

  assign four_bit_number = num_q;
  assign digit_valid     = dv_q;
  assign frame_valid     = frame_q;
  assign pattern_error   = err_q;

endmodule

// File: tb/tb_seven_segment_scan_decoder.sv
// Directed bench for seven_segment_scan_decoder with hand-computed expectations.
module tb_seven_segment_scan_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  seven_segment_number;
  logic        common_anod;
  logic [3:0]  digit_enable;
  logic [15:0] four_bit_number;
  logic [3:0]  digit_valid;
  logic        frame_valid;
  logic        pattern_error;

  int tests  = 0;
  int fails  = 0;
  int frames = 0;
  int errs   = 0;
  int frames_base;
  int errs_base;

  always #5 clk = ~clk;

  seven_segment_scan_decoder #(.STABLE_CYCLES(4)) dut (
    .clk                  (clk),
    .reset                (reset),
    .seven_segment_number (seven_segment_number),
    .common_anod          (common_anod),
    .digit_enable         (digit_enable),
    .four_bit_number      (four_bit_number),
    .digit_valid          (digit_valid),
    .frame_valid          (frame_valid),
    .pattern_error        (pattern_error)
  );

  // Pulse counters sampled away from the active edge.
  always @(negedge clk) begin
    if (frame_valid)   frames <= frames + 1;
    if (pattern_error) errs   <= errs + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic hold(input logic [3:0] en, input logic ca, input logic [6:0] pat, input int n);
    digit_enable         = en;
    common_anod          = ca;
    seven_segment_number = pat;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    hold(4'b0000, 1'b1, 7'b1111111, n);
  endtask

  initial begin
    reset = 1'b1;
    idle(3);
    check("rst_num",   32'(four_bit_number), 32'h0000);
    check("rst_dv",    32'(digit_valid),     32'h0);
    check("rst_frame", 32'(frame_valid),     32'h0);
    check("rst_err",   32'(pattern_error),   32'h0);
    reset = 1'b0;
    idle(2);

    // Glyph 3, common anode; visible exactly after the fifth edge.
    hold(4'b0001, 1'b1, 7'b0110000, 4);
    check("t1_dv_early", 32'(digit_valid), 32'h0);
    hold(4'b0001, 1'b1, 7'b0110000, 1);
    check("t1_dv",  32'(digit_valid),     32'h1);
    check("t1_num", 32'(four_bit_number), 32'h0003);
    hold(4'b0001, 1'b1, 7'b0110000, 3);
    idle(3);
    check("t1_err", 32'(errs), 32'd0);

    // Common cathode: inverted glyphs 1..4 across all four digits.
    frames_base = frames;
    hold(4'b0001, 1'b0, ~7'b1111001, 6);
    hold(4'b0010, 1'b0, ~7'b0100100, 6);
    hold(4'b0100, 1'b0, ~7'b0110000, 6);
    hold(4'b1000, 1'b0, ~7'b0011001, 6);
    idle(4);
    check("t2_num",   32'(four_bit_number), 32'h4321);
    check("t2_dv",    32'(digit_valid),     32'hf);
    check("t2_frame", 32'(frames - frames_base), 32'd1);

    // Illegal pattern on digit 1.
    errs_base = errs;
    hold(4'b0010, 1'b1, 7'b1010101, 8);
    idle(3);
    check("t3_err", 32'(errs - errs_base),  32'd1);
    check("t3_dv",  32'(digit_valid),     32'hd);
    check("t3_num", 32'(four_bit_number), 32'h4321);

    // Blank on digit 2: invalidates without error.
    errs_base = errs;
    hold(4'b0100, 1'b1, 7'b1111111, 6);
    idle(3);
    check("blank_err", 32'(errs - errs_base),  32'd0);
    check("blank_dv",  32'(digit_valid),     32'h9);
    check("blank_num", 32'(four_bit_number), 32'h4321);

    // Pattern toggling every 3 cycles never stabilises.
    errs_base = errs;
    for (int i = 0; i < 6; i++)
      hold(4'b0100, 1'b1, (i % 2 == 0) ? 7'b1111000 : 7'b0000000, 3);
    idle(4);
    check("t4_num", 32'(four_bit_number), 32'h4321);
    check("t4_dv",  32'(digit_valid),     32'h9);
    check("t4_err", 32'(errs - errs_base), 32'd0);

    // Two strobes at once is never captured.
    hold(4'b0011, 1'b1, 7'b0010010, 10);
    idle(2);
    check("t5_multi_num", 32'(four_bit_number), 32'h4321);
    check("t5_multi_dv",  32'(digit_valid),     32'h9);

    // Capture digits 0-2 (glyphs 5,6,7), then reset mid-frame.
    frames_base = frames;
    hold(4'b0001, 1'b1, 7'b0010010, 6);
    hold(4'b0010, 1'b1, 7'b0000010, 6);
    hold(4'b0100, 1'b1, 7'b1111000, 6);
    idle(3);
    check("t5_pre_num",   32'(four_bit_number), 32'h4765);
    check("t5_pre_dv",    32'(digit_valid),     32'hf);
    check("t5_pre_frame", 32'(frames - frames_base), 32'd0);

    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(1);
    check("t5_rst_num",   32'(four_bit_number), 32'h0000);
    check("t5_rst_dv",    32'(digit_valid),     32'h0);
    check("t5_rst_frame", 32'(frame_valid),     32'h0);
    check("t5_rst_err",   32'(pattern_error),   32'h0);

    // Fresh frame: digit 3 first so a stale mask would complete too early.
    frames_base = frames;
    hold(4'b1000, 1'b1, 7'b0001000, 6);
    hold(4'b0001, 1'b1, 7'b0000011, 6);
    hold(4'b0010, 1'b1, 7'b1000110, 6);
    idle(3);
    check("t5_partial_frame", 32'(frames - frames_base), 32'd0);
    hold(4'b0100, 1'b1, 7'b0100001, 6);
    idle(4);
    check("t5_frame", 32'(frames - frames_base), 32'd1);
    check("t5_num",   32'(four_bit_number), 32'hadcb);
    check("t5_dv",    32'(digit_valid),     32'hf);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
